fp_addsub_pipe: RTL and testbench

//  Pipelined, parametrised IEEE-754-style floating-point adder/subtractor; successor to the combinational 32-bit add/sub datapath.

---
 rtl/fp_addsub_pipe.sv | 192 +++++++++++++++++++
 tb/tb_fp_addsub_pipe.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/fp_addsub_pipe.sv
// Three-stage pipelined floating-point add/sub (align, add, normalise/round) with valid/ready flow control.
// Define FP_ADDSUB_SPECIAL_EN to decode all-ones exponents as IEEE Inf/NaN; otherwise they are ordinary finite values.
module fp_addsub_pipe #(
  parameter  int EXP_W = 8,
  parameter  int MAN_W = 23,
  localparam int W     = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_op,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_f,
  output logic         out_ovf,
  output logic         out_unf
);
  localparam int MW = MAN_W + 4;   // hidden + fraction + guard/round/sticky
  localparam int XW = EXP_W + 2;
  localparam logic [EXP_W-1:0]        DMAX = EXP_W'(MAN_W + 2);
  localparam logic signed [XW-1:0]    EOVF = XW'((1 << EXP_W) - 1);
  localparam logic [W-1:0]            QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  typedef struct packed {
    logic             sx;
    logic             zs;
    logic             sub;
    logic [EXP_W-1:0] ex;
    logic [MW-1:0]    mx;
    logic [MW-1:0]    my;
    logic             spec;
    logic [W-1:0]     spec_f;
  } s1_t;

  typedef struct packed {
    logic             sx;
    logic             zs;
    logic [EXP_W-1:0] ex;
    logic [MW:0]      sum;
    logic             spec;
    logic [W-1:0]     spec_f;
  } s2_t;

  s1_t s1_d, s1_q;
  s2_t s2_d, s2_q;
  logic [3:1] vld_q;
  logic       en1, en2, en3;
  logic [W-1:0] out_f_d, out_f_q;
  logic         out_ovf_d, out_ovf_q, out_unf_d, out_unf_q;

  // Each stage can load when it is empty or its contents leave this cycle.
  assign en3       = ~vld_q[3] | out_ready;
  assign en2       = ~vld_q[2] | en3;
  assign en1       = ~vld_q[1] | en2;
  assign in_ready  = en1;
  assign out_valid = vld_q[3];
  assign out_f     = out_f_q;
  assign out_ovf   = out_ovf_q;
  assign out_unf   = out_unf_q;

  // Stage 1: flush denormals, order by magnitude, align the smaller operand.
  logic             sa, sb, swap, sx, sy;
  logic [EXP_W-1:0] ea, eb, ex, ey, dexp;
  logic [MAN_W-1:0] fa, fb, fx, fy;
  logic [MW-1:0]    yfull, ysh;
  always_comb begin
    s1_d  = '0;
    sa    = in_a[W-1];
    sb    = in_b[W-1] ^ in_op;
    ea    = in_a[W-2:MAN_W];
    eb    = in_b[W-2:MAN_W];
    fa    = (ea == '0) ? '0 : in_a[MAN_W-1:0];
    fb    = (eb == '0) ? '0 : in_b[MAN_W-1:0];
    swap  = {eb, fb} > {ea, fa};
    sx    = swap ? sb : sa;
    sy    = swap ? sa : sb;
    ex    = swap ? eb : ea;
    ey    = swap ? ea : eb;
    fx    = swap ? fb : fa;
    fy    = swap ? fa : fb;
    dexp  = ex - ey;
    yfull = {(ey != '0), fy, 3'b000};
    if (dexp > DMAX) begin
      ysh = {{(MW-1){1'b0}}, (yfull != '0)};
    end else begin
      ysh = yfull >> dexp;
      if (((yfull >> dexp) << dexp) != yfull) ysh[0] = 1'b1;
    end
    s1_d.sx  = sx;
    s1_d.zs  = sx & sy;
    s1_d.sub = sx ^ sy;
    s1_d.ex  = ex;
    s1_d.mx  = {(ex != '0), fx, 3'b000};
    s1_d.my  = ysh;
`ifdef FP_ADDSUB_SPECIAL_EN
    begin
      logic a_inf, a_nan, b_inf, b_nan;
      a_nan = (ea == '1) && (in_a[MAN_W-1:0] != '0);
      b_nan = (eb == '1) && (in_b[MAN_W-1:0] != '0);
      a_inf = (ea == '1) && (in_a[MAN_W-1:0] == '0);
      b_inf = (eb == '1) && (in_b[MAN_W-1:0] == '0);
      s1_d.spec   = a_nan | b_nan | a_inf | b_inf;
      s1_d.spec_f = QNAN;
      if (a_nan | b_nan)       s1_d.spec_f = QNAN;
      else if (a_inf & b_inf)  s1_d.spec_f = (sa == sb) ? {sa, {EXP_W{1'b1}}, {MAN_W{1'b0}}} : QNAN;
      else if (a_inf)          s1_d.spec_f = {sa, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      else if (b_inf)          s1_d.spec_f = {sb, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end
`else
    s1_d.spec   = 1'b0;
    s1_d.spec_f = '0;
`endif
  end

  // Stage 2: magnitude add/subtract; after the swap the difference is never negative.
  always_comb begin
    s2_d        = '0;
    s2_d.sx     = s1_q.sx;
    s2_d.zs     = s1_q.zs;
    s2_d.ex     = s1_q.ex;
    s2_d.sum    = s1_q.sub ? ({1'b0, s1_q.mx} - {1'b0, s1_q.my})
                           : ({1'b0, s1_q.mx} + {1'b0, s1_q.my});
    s2_d.spec   = s1_q.spec;
    s2_d.spec_f = s1_q.spec_f;
  end

  // Stage 3: normalise, round to nearest even, then saturate or flush.
  logic [XW-1:0]    lz, e;
  logic [MW-1:0]    norm;
  logic [MAN_W+1:0] rnd;
  logic             up, found;
  always_comb begin
    lz    = '0;
    found = 1'b0;
    for (int i = MW-1; i >= 0; i--) begin
      if (!found) begin
        if (s2_q.sum[i]) found = 1'b1;
        else             lz    = lz + 1'b1;
      end
    end
    if (s2_q.sum[MW]) begin
      norm = {s2_q.sum[MW:2], s2_q.sum[1] | s2_q.sum[0]};
      e    = {2'b00, s2_q.ex} + 1'b1;
    end else begin
      norm = s2_q.sum[MW-1:0] << lz;
      e    = {2'b00, s2_q.ex} - lz;
    end
    up  = norm[2] & (norm[1] | norm[0] | norm[3]);
    rnd = {1'b0, norm[MW-1:3]} + {{(MAN_W+1){1'b0}}, up};
    if (rnd[MAN_W+1]) e = e + 1'b1;
    out_f_d   = {s2_q.sx, e[EXP_W-1:0], rnd[MAN_W+1] ? rnd[MAN_W:1] : rnd[MAN_W-1:0]};
    out_ovf_d = 1'b0;
    out_unf_d = 1'b0;
    if (s2_q.spec) begin
      out_f_d = s2_q.spec_f;
    end else if (s2_q.sum == '0) begin
      out_f_d = {s2_q.zs, {(W-1){1'b0}}};
    end else if ($signed(e) >= EOVF) begin
      out_f_d   = {s2_q.sx, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      out_ovf_d = 1'b1;
    end else if (e[XW-1] || (e == '0)) begin
      out_f_d   = '0;
      out_unf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q     <= '0;
      out_f_q   <= '0;
      out_ovf_q <= 1'b0;
      out_unf_q <= 1'b0;
    end else begin
      if (en1) vld_q[1] <= in_valid;
      if (en2) vld_q[2] <= vld_q[1];
      if (en3) vld_q[3] <= vld_q[2];
      if (en3 & vld_q[2]) begin
        out_f_q   <= out_f_d;
        out_ovf_q <= out_ovf_d;
        out_unf_q <= out_unf_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (en1 & in_valid) s1_q <= s1_d;
    if (en2 & vld_q[1]) s2_q <= s2_d;
  end
endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Directed bench for fp_addsub_pipe: vector table, streaming with back-pressure, reset with ops in flight.
`timescale 1ns/1ps
module tb_fp_addsub_pipe;
  logic        clk = 1'b0, rst = 1'b1;
  logic        in_valid = 1'b0, in_op = 1'b0, out_ready = 1'b1;
  logic        in_ready, out_valid, out_ovf, out_unf;
  logic [31:0] in_a = '0, in_b = '0, out_f;

  fp_addsub_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
    .out_f(out_f), .out_ovf(out_ovf), .out_unf(out_unf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        op;
    logic [31:0] a, b, f;
    logic        ovf, unf;
  } vec_t;

  localparam int NV = 23;
  vec_t        vt [NV];
  logic [31:0] fv [10];
  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    int lat;
    @(negedge clk);
    in_a = v.a; in_b = v.b; in_op = v.op; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    chk({nm, "_rdy"}, {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    chk({nm, "_lat"}, 32'(lat), 32'd3);
    chk(nm, out_f, v.f);
    chk({nm, "_flags"}, {30'b0, out_ovf, out_unf}, {30'b0, v.ovf, v.unf});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent, got;
    logic held_v, saw_drop, extra;
    logic [31:0] held_f;

    vt[0]  = '{1'b0, 32'h3F800000, 32'h3F800000, 32'h40000000, 1'b0, 1'b0};
    vt[1]  = '{1'b1, 32'h40400000, 32'h40A00000, 32'hC0000000, 1'b0, 1'b0};
    vt[2]  = '{1'b1, 32'h3F800000, 32'h3F800000, 32'h00000000, 1'b0, 1'b0};
    vt[3]  = '{1'b0, 32'h3F800000, 32'h33800000, 32'h3F800000, 1'b0, 1'b0};
    vt[4]  = '{1'b0, 32'h3F800000, 32'h33800001, 32'h3F800001, 1'b0, 1'b0};
    vt[5]  = '{1'b0, 32'h3F800001, 32'h33800000, 32'h3F800002, 1'b0, 1'b0};
    vt[6]  = '{1'b0, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 1'b1, 1'b0};
    vt[7]  = '{1'b0, 32'hFF7FFFFF, 32'hFF7FFFFF, 32'hFF800000, 1'b1, 1'b0};
    vt[8]  = '{1'b1, 32'h00800000, 32'h00800001, 32'h00000000, 1'b0, 1'b1};
    vt[9]  = '{1'b1, 32'h00C00000, 32'h00800000, 32'h00000000, 1'b0, 1'b1};
    vt[10] = '{1'b0, 32'h80000000, 32'h80000000, 32'h80000000, 1'b0, 1'b0};
    vt[11] = '{1'b1, 32'h80000000, 32'h00000000, 32'h80000000, 1'b0, 1'b0};
    vt[12] = '{1'b1, 32'h00000000, 32'h00000000, 32'h00000000, 1'b0, 1'b0};
    vt[13] = '{1'b0, 32'h00000001, 32'h3F800000, 32'h3F800000, 1'b0, 1'b0};
    vt[14] = '{1'b0, 32'h3FC00000, 32'h3FC00000, 32'h40400000, 1'b0, 1'b0};
    vt[15] = '{1'b0, 32'h40000000, 32'hBF800000, 32'h3F800000, 1'b0, 1'b0};
    vt[16] = '{1'b0, 32'hBF800000, 32'h3F000000, 32'hBF000000, 1'b0, 1'b0};
    vt[17] = '{1'b1, 32'h3F800000, 32'h00800000, 32'h3F800000, 1'b0, 1'b0};
    vt[18] = '{1'b0, 32'h3F800000, 32'h00800000, 32'h3F800000, 1'b0, 1'b0};
    vt[19] = '{1'b0, 32'h7E800000, 32'h7E800000, 32'h7F000000, 1'b0, 1'b0};
`ifdef FP_ADDSUB_SPECIAL_EN
    vt[20] = '{1'b0, 32'h7F800000, 32'h00000000, 32'h7F800000, 1'b0, 1'b0};
    vt[21] = '{1'b1, 32'h7F800000, 32'h7F800000, 32'h7FC00000, 1'b0, 1'b0};
    vt[22] = '{1'b0, 32'h7FC00001, 32'h3F800000, 32'h7FC00000, 1'b0, 1'b0};
`else
    vt[20] = '{1'b0, 32'h7F800000, 32'h00000000, 32'h7F800000, 1'b1, 1'b0};
    vt[21] = '{1'b1, 32'h7F800000, 32'h7F800000, 32'h00000000, 1'b0, 1'b0};
    vt[22] = '{1'b0, 32'h7FC00001, 32'h3F800000, 32'h7F800000, 1'b1, 1'b0};
`endif
    fv[0] = 32'h3F800000; fv[1] = 32'h40000000; fv[2] = 32'h40400000; fv[3] = 32'h40800000;
    fv[4] = 32'h40A00000; fv[5] = 32'h40C00000; fv[6] = 32'h40E00000; fv[7] = 32'h41000000;
    fv[8] = 32'h41100000; fv[9] = 32'h41200000;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_f", out_f, 32'd0);
    chk("rst_flags", {30'b0, out_ovf, out_unf}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);

    for (int i = 0; i < NV; i++) run_vec(vt[i], $sformatf("vec%0d", i));

    // 8-op stream, output back-pressured in cycles 2..5
    sent = 0; got = 0; held_v = 1'b0; saw_drop = 1'b0; held_f = '0;
    for (int c = 0; c < 60 && got < 8; c++) begin
      @(negedge clk);
      out_ready = !(c >= 2 && c <= 5);
      in_valid  = (sent < 8);
      in_a      = fv[sent];
      in_b      = 32'h3F800000;
      in_op     = 1'b0;
      #1;
      if (held_v) chk("stall_hold", out_f, held_f);
      if (in_valid && !in_ready) saw_drop = 1'b1;
      if (in_valid && in_ready) sent++;
      if (out_valid && out_ready) begin
        chk($sformatf("stream%0d", got), out_f, fv[got+1]);
        got++;
      end
      held_v = out_valid && !out_ready;
      held_f = out_f;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("stream_count", 32'(got), 32'd8);
    chk("in_ready_drop", {31'b0, saw_drop}, 32'd1);
    extra = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) extra = 1'b1;
    end
    chk("stream_no_dup", {31'b0, extra}, 32'd0);

    // reset with two ops in flight
    @(negedge clk);
    in_a = 32'h3F800000; in_b = 32'h3F800000; in_op = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_a = 32'h40000000;
    @(negedge clk);
    in_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_valid", {31'b0, out_valid}, 32'd0);
    chk("midrst_f", out_f, 32'd0);
    extra = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) extra = 1'b1;
    end
    chk("midrst_no_ghost", {31'b0, extra}, 32'd0);
    run_vec(vt[14], "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
